gen_chan_delay: RTL and testbench

Multi-channel registered delay array built from a generate loop.
- Each of NCHAN channels is a WIDTH-bit shift pipeline with a valid bit.
- Per-channel depth is selected by a generate if/else on channel index parity: DEPTH_EVEN for even channels, DEPTH_ODD for odd channels.
- A shared stall (en) and flush act on all channels; a 64-bit LFSR signature accumulator compacts the outputs for self-checking regression benches.
- Successor to the single-bit per-lane register arrays: generalises width, depth and channel count, and adds valid tracking, stall, flush and signature.

---
 rtl/gen_chan_pkg.sv | 20 ++
 rtl/chan_pipe.sv | 55 +++++
 rtl/gen_chan_delay.sv | 103 ++++++++++
 tb/tb_gen_chan_delay.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/gen_chan_pkg.sv
// Shared constants and the signature LFSR step for the gen_chan_delay array.
package gen_chan_pkg;

    localparam int unsigned SIG_TAP_A = 2;
    localparam int unsigned SIG_TAP_B = 0;
    localparam int unsigned MAX_SIG_W = 256;

    // Rotate-left of the low w bits with bit 0 replaced by the feedback taps.
    function automatic logic [MAX_SIG_W-1:0] lfsr_next(input logic [MAX_SIG_W-1:0] s,
                                                       input int unsigned w);
        logic [MAX_SIG_W-1:0] r;
        r = '0;
        for (int unsigned i = 1; i < MAX_SIG_W; i++) begin
            if (i < w) r[i] = s[i-1];
        end
        r[0] = s[w-1] ^ s[SIG_TAP_A] ^ s[SIG_TAP_B];
        return r;
    endfunction

endpackage

// File: rtl/chan_pipe.sv
// One channel of the delay array: DEPTH-stage data shift pipeline with valid tracking.
module chan_pipe #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             flush,
    input  logic [WIDTH-1:0] d,
    input  logic             d_valid,
    output logic [WIDTH-1:0] q,
    output logic             q_valid,
    output logic [WIDTH-1:0] stage0
);

    if (DEPTH < 1) begin : g_bad_depth
        $error("chan_pipe: DEPTH must be >= 1");
    end

    logic [WIDTH-1:0] data_q [DEPTH];
    logic [WIDTH-1:0] data_d [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] valid_d;

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        if (en) begin
            data_d[0]  = d;
            valid_d[0] = d_valid;
            for (int unsigned k = 1; k < DEPTH; k++) begin
                data_d[k]  = data_q[k-1];
                valid_d[k] = valid_q[k-1];
            end
        end
        // Flush overrides the freshly captured valid as well.
        if (flush) valid_d = '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q  <= '{default: '0};
            valid_q <= '0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign q       = data_q[DEPTH-1];
    assign q_valid = valid_q[DEPTH-1];
    assign stage0  = data_q[0];

endmodule

// File: rtl/gen_chan_delay.sv
// Multi-channel registered delay array with parity-selected depths, shared stall/flush
// and a masked-output LFSR signature.
module gen_chan_delay
    import gen_chan_pkg::*;
#(
    parameter int unsigned NCHAN      = 4,
    parameter int unsigned WIDTH      = 1,
    parameter int unsigned DEPTH_EVEN = 1,
    parameter int unsigned DEPTH_ODD  = 2,
    parameter int unsigned SIG_W      = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   en,
    input  logic                   flush,
    input  logic                   in_valid,
    input  logic [NCHAN*WIDTH-1:0] value,
    output logic [NCHAN*WIDTH-1:0] result,
    output logic [NCHAN-1:0]       result_valid,
    output logic [NCHAN*WIDTH-1:0] tap,
    input  logic                   sig_clear,
    output logic [SIG_W-1:0]       sig
);

    if (NCHAN < 1 || WIDTH < 1) begin : g_bad_shape
        $error("gen_chan_delay: NCHAN and WIDTH must be >= 1");
    end
    if (DEPTH_EVEN < 1 || DEPTH_ODD < 1) begin : g_bad_depth
        $error("gen_chan_delay: DEPTH_EVEN and DEPTH_ODD must be >= 1");
    end
    if (SIG_W < 3 || SIG_W < NCHAN * WIDTH || SIG_W > MAX_SIG_W) begin : g_bad_sig
        $error("gen_chan_delay: SIG_W must be >= 3, >= NCHAN*WIDTH and <= MAX_SIG_W");
    end

    for (genvar c = 0; c < NCHAN; c++) begin : ch
        if (c % 2 == 0) begin : gblk
            chan_pipe #(
                .WIDTH(WIDTH),
                .DEPTH(DEPTH_EVEN)
            ) pipe (
                .clk    (clk),
                .reset  (reset),
                .en     (en),
                .flush  (flush),
                .d      (value[c*WIDTH +: WIDTH]),
                .d_valid(in_valid),
                .q      (result[c*WIDTH +: WIDTH]),
                .q_valid(result_valid[c]),
                .stage0 (tap[c*WIDTH +: WIDTH])
            );
        end else begin : gblk
            chan_pipe #(
                .WIDTH(WIDTH),
                .DEPTH(DEPTH_ODD)
            ) pipe (
                .clk    (clk),
                .reset  (reset),
                .en     (en),
                .flush  (flush),
                .d      (value[c*WIDTH +: WIDTH]),
                .d_valid(in_valid),
                .q      (result[c*WIDTH +: WIDTH]),
                .q_valid(result_valid[c]),
                .stage0 (tap[c*WIDTH +: WIDTH])
            );
        end
    end

    logic [SIG_W-1:0]     masked;
    logic [MAX_SIG_W-1:0] shift_full_unused;
    logic [SIG_W-1:0]     sig_q;
    logic [SIG_W-1:0]     sig_d;

    always_comb begin
        masked = '0;
        for (int unsigned c = 0; c < NCHAN; c++) begin
            masked[c*WIDTH +: WIDTH] = result_valid[c] ? result[c*WIDTH +: WIDTH] : '0;
        end
    end

    // Helper works at the package's maximum width; only the low SIG_W bits are meaningful.
    assign shift_full_unused = lfsr_next(MAX_SIG_W'(sig_q), SIG_W);

    always_comb begin
        sig_d = sig_q;
        if (sig_clear) begin
            sig_d = '0;
        end else if (en) begin
            sig_d = masked ^ shift_full_unused[SIG_W-1:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sig_q <= '0;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig = sig_q;

endmodule

// File: tb/tb_gen_chan_delay.sv
// Scoreboard bench for gen_chan_delay: history-based reference model feeds an expected queue,
// a negedge monitor pops and compares.
module tb_gen_chan_delay;

    localparam int NCHAN      = 4;
    localparam int WIDTH      = 1;
    localparam int DEPTH_EVEN = 1;
    localparam int DEPTH_ODD  = 2;
    localparam int SIG_W      = 64;
    localparam int NW         = NCHAN * WIDTH;
    localparam int MAXD       = (DEPTH_EVEN > DEPTH_ODD) ? DEPTH_EVEN : DEPTH_ODD;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              en = 1'b0;
    logic              flush = 1'b0;
    logic              in_valid = 1'b0;
    logic              sig_clear = 1'b0;
    logic [NW-1:0]     value = '0;
    logic [NW-1:0]     result;
    logic [NW-1:0]     tap;
    logic [NCHAN-1:0]  result_valid;
    logic [SIG_W-1:0]  sig;

    gen_chan_delay #(
        .NCHAN     (NCHAN),
        .WIDTH     (WIDTH),
        .DEPTH_EVEN(DEPTH_EVEN),
        .DEPTH_ODD (DEPTH_ODD),
        .SIG_W     (SIG_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .flush       (flush),
        .in_valid    (in_valid),
        .value       (value),
        .result      (result),
        .result_valid(result_valid),
        .tap         (tap),
        .sig_clear   (sig_clear),
        .sig         (sig)
    );

    always #5 clk = ~clk;

    // Enabled-input history; an entry is valid only if no flush happened since it was taken.
    typedef struct {
        logic [NW-1:0] data;
        logic          ivalid;
        int unsigned   epoch;
    } entry_t;

    typedef struct {
        logic [NW-1:0]    result;
        logic [NCHAN-1:0] rv;
        logic [NW-1:0]    tap;
        logic [SIG_W-1:0] sig;
    } exp_t;

    entry_t           hist[$];
    exp_t             expq[$];
    int unsigned      flush_cnt = 0;
    logic [SIG_W-1:0] m_sig = '0;
    int               n_cmp = 0;
    int               n_bad = 0;

    function automatic int depth_of(int c);
        return (c % 2 == 0) ? DEPTH_EVEN : DEPTH_ODD;
    endfunction

    function automatic exp_t model_out();
        exp_t e;
        e.result = '0;
        e.rv     = '0;
        e.tap    = '0;
        e.sig    = m_sig;
        for (int c = 0; c < NCHAN; c++) begin
            if (hist.size() >= depth_of(c)) begin
                entry_t h;
                h = hist[hist.size() - depth_of(c)];
                e.result[c*WIDTH +: WIDTH] = h.data[c*WIDTH +: WIDTH];
                e.rv[c] = h.ivalid && (h.epoch == flush_cnt);
            end
            if (hist.size() >= 1) begin
                entry_t t;
                t = hist[hist.size() - 1];
                e.tap[c*WIDTH +: WIDTH] = t.data[c*WIDTH +: WIDTH];
            end
        end
        return e;
    endfunction

    task automatic model_step();
        exp_t             pre;
        logic [SIG_W-1:0] masked;
        entry_t           ne;
        if (reset) begin
            hist.delete();
            flush_cnt = 0;
            m_sig = '0;
            return;
        end
        pre = model_out();
        masked = '0;
        for (int c = 0; c < NCHAN; c++) begin
            if (pre.rv[c]) masked[c*WIDTH +: WIDTH] = pre.result[c*WIDTH +: WIDTH];
        end
        if (sig_clear) m_sig = '0;
        else if (en) m_sig = masked ^ {m_sig[SIG_W-2:0], m_sig[SIG_W-1] ^ m_sig[2] ^ m_sig[0]};
        if (en) begin
            ne.data = value;
            ne.ivalid = in_valid;
            ne.epoch = flush_cnt;
            hist.push_back(ne);
            if (hist.size() > MAXD) void'(hist.pop_front());
        end
        if (flush) flush_cnt++;
    endtask

    task automatic chk(input string name, input logic [SIG_W-1:0] act, input logic [SIG_W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic e, input logic f, input logic iv,
                        input logic [NW-1:0] v, input logic sc);
        @(negedge clk);
        #1;
        reset = r; en = e; flush = f; in_valid = iv; value = v; sig_clear = sc;
        @(posedge clk);
        model_step();
        expq.push_back(model_out());
        #1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (expq.size() > 0) begin
                e = expq.pop_front();
                chk("result", SIG_W'(result), SIG_W'(e.result));
                chk("result_valid", SIG_W'(result_valid), SIG_W'(e.rv));
                chk("tap", SIG_W'(tap), SIG_W'(e.tap));
                chk("sig", sig, e.sig);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1, "timeout");
    end

    initial begin : driver
        step(1, 0, 0, 0, '0, 0);
        step(1, 0, 0, 0, '0, 0);
        step(0, 1, 0, 0, '0, 0);

        // Reset in the middle of valid traffic.
        repeat (3) step(0, 1, 0, 1, 4'hF, 0);
        @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("rst_result", SIG_W'(result), '0);
        chk("rst_valid", SIG_W'(result_valid), '0);
        chk("rst_tap", SIG_W'(tap), '0);
        chk("rst_sig", sig, '0);
        @(posedge clk);
        model_step();
        expq.push_back(model_out());
        step(0, 1, 0, 1, 4'hF, 0);
        chk("rst_first_valid", SIG_W'(result_valid), SIG_W'(4'b0101));

        // Latency split between even and odd channels.
        step(0, 1, 1, 0, '0, 0);
        repeat (2) step(0, 1, 0, 0, '0, 0);
        step(0, 1, 0, 1, 4'hF, 0);
        chk("lat1_result", SIG_W'(result), SIG_W'(4'b0101));
        chk("lat1_valid", SIG_W'(result_valid), SIG_W'(4'b0101));
        step(0, 1, 0, 0, '0, 0);
        chk("lat2_result", SIG_W'(result), SIG_W'(4'b1010));
        chk("lat2_valid", SIG_W'(result_valid), SIG_W'(4'b1010));
        step(0, 1, 0, 0, '0, 0);
        chk("lat3_valid", SIG_W'(result_valid), '0);

        // Stall holds everything for three cycles, then the sequence resumes.
        step(0, 1, 0, 1, 4'hF, 0);
        repeat (3) begin
            step(0, 0, 0, 1, 4'h3, 0);
            chk("stall_result", SIG_W'(result), SIG_W'(4'b0101));
            chk("stall_valid", SIG_W'(result_valid), SIG_W'(4'b0101));
        end
        step(0, 1, 0, 0, '0, 0);
        chk("resume_result", SIG_W'(result), SIG_W'(4'b1010));
        chk("resume_valid", SIG_W'(result_valid), SIG_W'(4'b1010));
        step(0, 1, 0, 0, '0, 0);
        chk("resume_end", SIG_W'(result_valid), '0);

        // Flush with en and in_valid: valids drop, data still flows.
        repeat (2) step(0, 1, 0, 1, 4'hF, 0);
        step(0, 1, 1, 1, 4'hF, 0);
        chk("flush_valid", SIG_W'(result_valid), '0);
        step(0, 1, 0, 0, '0, 0);
        chk("flush_data", SIG_W'(result), SIG_W'(4'b1010));
        chk("flush_data_valid", SIG_W'(result_valid), '0);

        // Signature from a constant masked output of 4'b0101.
        repeat (2) step(0, 1, 0, 1, 4'h5, 0);
        step(0, 1, 0, 1, 4'h5, 1);
        chk("sig_clear", sig, '0);
        step(0, 1, 0, 1, 4'h5, 0);
        chk("sig_1", sig, 64'h5);
        step(0, 1, 0, 1, 4'h5, 0);
        chk("sig_2", sig, 64'hF);
        step(0, 1, 0, 1, 4'h5, 0);
        chk("sig_3", sig, 64'h1B);

        // Randomized regression.
        for (int i = 0; i < 100; i++) begin
            step(0, ($urandom_range(0, 9) != 0), ($urandom_range(0, 19) == 0), 1'($urandom),
                 NW'($urandom), ($urandom_range(0, 29) == 0));
        end

        @(negedge clk);
        #2;
        chk("final_sig", sig, m_sig);
        chk("queue_drained", SIG_W'(expq.size()), '0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
